mtimer: RTL and testbench



---
 rtl/timer_pkg.sv | 16 +
 rtl/timer_prescaler.sv | 19 +
 rtl/mtimer.sv | 121 ++++++++++++
 tb/tb_mtimer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: register map, control bit positions and reset constants shared by the mtimer blocks.
package timer_pkg;
    localparam logic [1:0]  COMMIT_STATE    = 2'd3;
    localparam logic [2:0]  OFF_MTIME_LO    = 3'd0;
    localparam logic [2:0]  OFF_MTIME_HI    = 3'd1;
    localparam logic [2:0]  OFF_MTIMECMP_LO = 3'd2;
    localparam logic [2:0]  OFF_MTIMECMP_HI = 3'd3;
    localparam logic [2:0]  OFF_CTRL        = 3'd4;
    localparam logic [2:0]  OFF_STATUS      = 3'd5;
    localparam logic [2:0]  OFF_PRESCALE    = 3'd6;
    localparam int          CTRL_EN         = 0;
    localparam int          CTRL_IRQ_EN     = 1;
    localparam int          CTRL_RELOAD     = 2;
    localparam int          STATUS_PENDING  = 0;
    localparam logic [63:0] MTIMECMP_RST    = 64'hFFFF_FFFF_FFFF_FFFF;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides the core clock into one-cycle ticks every prescale+1 cycles while enabled.
module timer_prescaler (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] prescale,
    input  logic        clear,
    output logic        tick
);
    logic [15:0] pcnt_q, pcnt_d;

    assign tick   = enable && pcnt_q == prescale;
    assign pcnt_d = (!enable || clear || tick) ? 16'd0 : pcnt_q + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pcnt_q <= '0;
        else     pcnt_q <= pcnt_d;
    end
endmodule

// File: rtl/mtimer.sv
// mtimer: memory-mapped 64-bit machine timer with compare interrupt and prescaler.
// Define TIMER_SNAPSHOT_EN to latch MTIME_HI on a committed MTIME_LO load for tear-free 64-bit reads.
module mtimer
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  state,
    input  logic        en,
    input  logic        load_enable,
    input  logic        store_enable,
    input  logic        is_lb,
    input  logic        is_lbu,
    input  logic        is_lh,
    input  logic        is_lhu,
    input  logic        is_lw,
    input  logic        is_sb,
    input  logic        is_sh,
    input  logic        is_sw,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        irq
);
    logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
    logic [2:0]  ctrl_q, ctrl_d, off;
    logic [15:0] prescale_q, prescale_d, h;
    logic        pending_q, pending_d, irq_q, wr, tick, match, w1c;
    logic [31:0] bem, wdata, rd_word, mtime_hi_rd;
    logic [7:0]  hit, b;
    logic        unused;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [31:0] m);
        return (old & ~m) | (d & m);
    endfunction

    assign off    = address[4:2];
    assign wr     = en && store_enable && state == COMMIT_STATE;
    assign hit    = wr ? 8'd1 << off : 8'd0;
    // Store data is replicated into every lane; bem picks the lane(s) that actually change.
    assign wdata  = is_sb ? {4{data_in[7:0]}} : is_sh ? {2{data_in[15:0]}} : data_in;
    assign bem    = is_sw ? 32'hFFFF_FFFF
                  : is_sh ? (address[1] ? 32'hFFFF_0000 : 32'h0000_FFFF)
                  : is_sb ? 32'hFF << {address[1:0], 3'b000} : 32'h0;
    assign match  = mtime_q >= mtimecmp_q;
    assign w1c    = hit[OFF_STATUS] && bem[STATUS_PENDING] && wdata[STATUS_PENDING];
    assign unused = ^{address[31:5], is_lw};

    timer_prescaler u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .enable   (ctrl_q[CTRL_EN]),
        .prescale (prescale_q),
        .clear    (hit[OFF_PRESCALE]),
        .tick     (tick)
    );

    always_comb begin
        mtime_d    = !tick ? mtime_q : (ctrl_q[CTRL_RELOAD] && match) ? 64'd0 : mtime_q + 64'd1;
        if (hit[OFF_MTIME_LO]) mtime_d[31:0]  = merge(mtime_q[31:0], wdata, bem);
        if (hit[OFF_MTIME_HI]) mtime_d[63:32] = merge(mtime_q[63:32], wdata, bem);
        mtimecmp_d = mtimecmp_q;
        if (hit[OFF_MTIMECMP_LO]) mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0], wdata, bem);
        if (hit[OFF_MTIMECMP_HI]) mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], wdata, bem);
        ctrl_d     = hit[OFF_CTRL] ? (ctrl_q & ~bem[2:0]) | (wdata[2:0] & bem[2:0]) : ctrl_q;
        prescale_d = hit[OFF_PRESCALE] ? (prescale_q & ~bem[15:0]) | (wdata[15:0] & bem[15:0]) : prescale_q;
        pending_d  = match || (pending_q && !w1c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime_q    <= '0;
            mtimecmp_q <= MTIMECMP_RST;
            ctrl_q     <= '0;
            prescale_q <= '0;
            pending_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            pending_q  <= pending_d;
            irq_q      <= pending_q && ctrl_q[CTRL_IRQ_EN];
        end
    end

`ifdef TIMER_SNAPSHOT_EN
    logic [31:0] shadow_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) shadow_q <= '0;
        else if (en && load_enable && state == COMMIT_STATE && off == OFF_MTIME_LO) shadow_q <= mtime_q[63:32];
    end
    assign mtime_hi_rd = shadow_q;
`else
    assign mtime_hi_rd = mtime_q[63:32];
`endif

    always_comb begin
        case (off)
            OFF_MTIME_LO:    rd_word = mtime_q[31:0];
            OFF_MTIME_HI:    rd_word = mtime_hi_rd;
            OFF_MTIMECMP_LO: rd_word = mtimecmp_q[31:0];
            OFF_MTIMECMP_HI: rd_word = mtimecmp_q[63:32];
            OFF_CTRL:        rd_word = {29'b0, ctrl_q};
            OFF_STATUS:      rd_word = {31'b0, pending_q};
            OFF_PRESCALE:    rd_word = {16'b0, prescale_q};
            default:         rd_word = '0;
        endcase
    end

    assign b        = rd_word[{address[1:0], 3'b000} +: 8];
    assign h        = address[1] ? rd_word[31:16] : rd_word[15:0];
    assign data_out = !(en && load_enable) ? 32'd0
                    : is_lb  ? {{24{b[7]}}, b}
                    : is_lbu ? {24'b0, b}
                    : is_lh  ? {{16{h[15]}}, h}
                    : is_lhu ? {16'b0, h}
                    : rd_word;
    assign irq      = irq_q;
endmodule

// File: tb/tb_mtimer.sv
// tb_mtimer: directed self-checking bench for mtimer; each bus access occupies exactly one clock edge.
module tb_mtimer;
    logic        clk, rst, en, load_enable, store_enable;
    logic        is_lb, is_lbu, is_lh, is_lhu, is_lw, is_sb, is_sh, is_sw;
    logic [1:0]  state;
    logic [31:0] address, data_in, data_out, q;
    logic        irq;
    int          checks = 0, errors = 0, n;

    localparam logic [4:0] A_LO = 5'd0, A_HI = 5'd4, A_CLO = 5'd8, A_CHI = 5'd12, A_CTRL = 5'd16,
                           A_STAT = 5'd20, A_PRE = 5'd24, A_RSV = 5'd28;
    localparam int LB = 0, LBU = 1, LH = 2, LHU = 3, LW = 4, SB = 0, SH = 1, SW = 2;

    mtimer dut (
        .clk(clk), .rst(rst), .state(state), .en(en), .load_enable(load_enable), .store_enable(store_enable),
        .is_lb(is_lb), .is_lbu(is_lbu), .is_lh(is_lh), .is_lhu(is_lhu), .is_lw(is_lw),
        .is_sb(is_sb), .is_sh(is_sh), .is_sw(is_sw), .address(address), .data_in(data_in),
        .data_out(data_out), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        en = 0; load_enable = 0; store_enable = 0; state = 2'd0;
        {is_lb, is_lbu, is_lh, is_lhu, is_lw, is_sb, is_sh, is_sw} = '0;
    endtask

    // Called at a negedge; commits on the following posedge and returns at the next negedge.
    task automatic st(input logic [4:0] a, input logic [31:0] d, input int sz);
        en = 1; store_enable = 1; state = 2'd3; address = {27'b0, a}; data_in = d;
        is_sb = sz == SB; is_sh = sz == SH; is_sw = sz == SW;
        @(negedge clk);
        idle();
    endtask

    // Samples data_out before the edge; the access still commits on that edge (snapshot side effect).
    task automatic rd(input string tag, input logic [4:0] a, input int k, input logic [31:0] exp);
        en = 1; load_enable = 1; state = 2'd3; address = {27'b0, a};
        is_lb = k == LB; is_lbu = k == LBU; is_lh = k == LH; is_lhu = k == LHU; is_lw = k == LW;
        #1 q = data_out;
        chk(tag, q, exp);
        @(negedge clk);
        idle();
    endtask

    initial begin
        rst = 1; address = 0; data_in = 0;
        idle();
        repeat (2) @(negedge clk);
        chk("irq_in_reset", irq, 0);
        rst = 0;
        rd("rst_cmp_lo", A_CLO, LW, 32'hFFFF_FFFF);
        rd("rst_mtime_lo", A_LO, LW, 32'h0);
        rd("rst_ctrl", A_CTRL, LW, 32'h0);
        chk("rst_irq", irq, 0);
        #1 chk("idle_data_out", data_out, 0);

        // carry from LO into HI, prescale 0
        st(A_PRE, 32'h0, SW);
        st(A_CTRL, 32'h1, SW);
        st(A_LO, 32'hFFFF_FFFE, SW);
        rd("carry_lo0", A_LO, LW, 32'hFFFF_FFFE);
        rd("carry_hi0", A_HI, LW, 32'h0);
        rd("carry_lo2", A_LO, LW, 32'h0);
        rd("carry_hi3", A_HI, LW, 32'h1);
        st(A_CTRL, 32'h0, SW);
        rd("hold_lo_a", A_LO, LW, 32'h3);
        rd("hold_lo_b", A_LO, LW, 32'h3);

        // interrupt timing: mtime steps every 4 cycles, reaches 10 on edge 40
        st(A_LO, 32'h0, SW);
        st(A_HI, 32'h0, SW);
        st(A_CLO, 32'd10, SW);
        st(A_CHI, 32'h0, SW);
        st(A_PRE, 32'd3, SW);
        st(A_CTRL, 32'h3, SW);
        n = 0;
        while (!irq && n < 200) begin
            @(posedge clk);
            n++;
            #1;
        end
        chk("irq_rise_edge", n, 42);
        @(negedge clk);
        rd("mtime_at_irq", A_LO, LW, 32'd10);
        st(A_STAT, 32'h1, SW);
        rd("w1c_vs_match", A_STAT, LW, 32'h1);
        chk("irq_held", irq, 1);
        st(A_CHI, 32'h1, SW);
        st(A_STAT, 32'h1, SW);
        rd("w1c_clears", A_STAT, LW, 32'h0);
        chk("irq_dropped", irq, 0);

        // auto-reload 0..4
        st(A_CTRL, 32'h0, SW);
        st(A_LO, 32'h0, SW);
        st(A_HI, 32'h0, SW);
        st(A_CLO, 32'd4, SW);
        st(A_CHI, 32'h0, SW);
        st(A_PRE, 32'h0, SW);
        st(A_CTRL, 32'h7, SW);
        for (int i = 0; i < 11; i++) rd($sformatf("reload_%0d", i), A_LO, LW, 32'(i % 5));
        st(A_CTRL, 32'h0, SW);
        st(A_STAT, 32'h1, SW);

        // sub-word stores and load extension
        st(A_PRE, 32'h12, SW);
        st(5'd25, 32'hAB, SB);
        rd("pre_word", A_PRE, LW, 32'h0000_AB12);
        rd("pre_lb", 5'd25, LB, 32'hFFFF_FFAB);
        rd("pre_lbu", 5'd25, LBU, 32'h0000_00AB);
        rd("pre_lh", A_PRE, LH, 32'hFFFF_AB12);
        rd("pre_lhu_hi", 5'd26, LHU, 32'h0);
        st(A_CLO, 32'h1122_3344, SW);
        st(5'd10, 32'h5566, SH);
        rd("cmp_sh_word", A_CLO, LW, 32'h5566_3344);
        rd("cmp_lh_hi", 5'd10, LH, 32'h0000_5566);
        rd("cmp_lhu_lo", A_CLO, LHU, 32'h0000_3344);
        rd("cmp_lb_b3", 5'd11, LB, 32'h0000_0055);
        st(A_RSV, 32'hFFFF_FFFF, SW);
        rd("reserved", A_RSV, LW, 32'h0);
        st(A_CTRL, 32'hFFFF_FFF8, SW);
        rd("ctrl_rsv_bits", A_CTRL, LW, 32'h0);

        // snapshot: LO read latches HI, then a tick carries into the live HI
        st(A_PRE, 32'h0, SW);
        st(A_LO, 32'hFFFF_FFFF, SW);
        st(A_HI, 32'h0, SW);
        rd("snap_lo", A_LO, LW, 32'hFFFF_FFFF);
        st(A_CTRL, 32'h1, SW);
        @(negedge clk);
`ifdef TIMER_SNAPSHOT_EN
        rd("snap_hi", A_HI, LW, 32'h0);
`else
        rd("snap_hi", A_HI, LW, 32'h1);
`endif

        // asynchronous reset mid-count
        st(A_CTRL, 32'h3, SW);
        repeat (3) @(negedge clk);
        chk("irq_pre_reset", irq, 1);
        #2 rst = 1;
        #1 chk("irq_async_clr", irq, 0);
        @(negedge clk);
        rst = 0;
        rd("post_rst_stat", A_STAT, LW, 32'h0);
        rd("post_rst_lo_a", A_LO, LW, 32'h0);
        rd("post_rst_lo_b", A_LO, LW, 32'h0);
        rd("post_rst_hi", A_HI, LW, 32'h0);
        rd("post_rst_chi", A_CHI, LW, 32'hFFFF_FFFF);
        rd("post_rst_pre", A_PRE, LW, 32'h0);

        // a store outside the commit state is ignored
        en = 1; store_enable = 1; state = 2'd2; address = {27'b0, A_CTRL}; data_in = 32'h7; is_sw = 1;
        @(negedge clk);
        idle();
        rd("no_commit", A_CTRL, LW, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
